// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes A - B - Borrow_In one bit per clock
// through a 1-bit full-subtractor cell, with the borrow registered back into the cell.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (b & bin) | (~a & bin);
endmodule

// Handshake: Start_In is accepted on any rising edge where the block is idle
// (Busy_Out=0). While busy, Start_In is ignored. Done_Out is a single-cycle pulse.
// State_Dbg_Out exposes the FSM state: 0 = IDLE, 1 = SHIFT.
module serial_subtractor #(
   parameter int DATA_WIDTH = 8  // legal range 2..32
) (
   input  logic                  Clk_In,
   input  logic                  Reset_n_In,
   input  logic                  Start_In,
   input  logic [DATA_WIDTH-1:0] Data_A_In,
   input  logic [DATA_WIDTH-1:0] Data_B_In,
   input  logic                  Borrow_In,
   output logic                  Busy_Out,
   output logic                  Done_Out,
   output logic [DATA_WIDTH-1:0] Difference_Out,
   output logic                  Borrow_Out,
   output logic                  State_Dbg_Out
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] a_reg, a_nxt;
   logic [DATA_WIDTH-1:0] b_reg, b_nxt;
   logic [DATA_WIDTH-1:0] result_reg, result_nxt;
   logic                  borrow_reg, borrow_nxt;
   logic [CW-1:0]         bit_count, bit_count_nxt;
   logic                  busy_nxt, done_nxt, borrow_out_nxt;
   logic [DATA_WIDTH-1:0] difference_nxt;
   logic                  diff_bit, next_borrow;
   logic [DATA_WIDTH-1:0] shifted;

   full_subtractor u_cell (
      .a    (a_reg[0]),
      .b    (b_reg[0]),
      .bin  (borrow_reg),
      .diff (diff_bit),
      .bout (next_borrow)
   );

   // Result fills from the MSB end so the final bit lands LSB-aligned.
   assign shifted       = {diff_bit, result_reg[DATA_WIDTH-1:1]};
   assign State_Dbg_Out = (state == SHIFT);

   always_comb begin
      state_nxt      = state;
      a_nxt          = a_reg;
      b_nxt          = b_reg;
      result_nxt     = result_reg;
      borrow_nxt     = borrow_reg;
      bit_count_nxt  = bit_count;
      busy_nxt       = Busy_Out;
      done_nxt       = 1'b0;
      difference_nxt = Difference_Out;
      borrow_out_nxt = Borrow_Out;
      case (state)
         IDLE: begin
            if (Start_In) begin
               a_nxt         = Data_A_In;
               b_nxt         = Data_B_In;
               borrow_nxt    = Borrow_In;
               result_nxt    = '0;
               bit_count_nxt = '0;
               busy_nxt      = 1'b1;
               state_nxt     = SHIFT;
            end
         end
         SHIFT: begin
            a_nxt         = a_reg >> 1;
            b_nxt         = b_reg >> 1;
            result_nxt    = shifted;
            borrow_nxt    = next_borrow;
            bit_count_nxt = bit_count + 1'b1;
            if (bit_count == LAST) begin
               difference_nxt = shifted;
               borrow_out_nxt = next_borrow;
               done_nxt       = 1'b1;
               busy_nxt       = 1'b0;
               bit_count_nxt  = '0;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state          <= IDLE;
         a_reg          <= '0;
         b_reg          <= '0;
         result_reg     <= '0;
         borrow_reg     <= 1'b0;
         bit_count      <= '0;
         Busy_Out       <= 1'b0;
         Done_Out       <= 1'b0;
         Difference_Out <= '0;
         Borrow_Out     <= 1'b0;
      end else begin
         state          <= state_nxt;
         a_reg          <= a_nxt;
         b_reg          <= b_nxt;
         result_reg     <= result_nxt;
         borrow_reg     <= borrow_nxt;
         bit_count      <= bit_count_nxt;
         Busy_Out       <= busy_nxt;
         Done_Out       <= done_nxt;
         Difference_Out <= difference_nxt;
         Borrow_Out     <= borrow_out_nxt;
      end
   end

endmodule
